// File: rtl/prog_loader_pkg.sv
// Shared definitions for the program loader and the benches that drive it:
// controller state encoding, default bus widths shared with the microcode
// sequencer, and the sequencer control-field encoding for HALT.
package prog_loader_pkg;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_LOAD = 3'd1,
    ST_ARM  = 3'd2,
    ST_WLOW = 3'd3,
    ST_RUN  = 3'd4
  } state_e;

  localparam int ADDR_W_DEF = 8;
  localparam int DATA_W_DEF = 16;

  // Sequencer ctl_c field value that stops execution.
  localparam logic [1:0] CTL_HALT = 2'b10;

endpackage

// File: rtl/prog_loader_if.sv
// Valid/ready stream carrying microinstructions from the host into the loader.
interface prog_loader_if
  import prog_loader_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF
);
  logic              s_valid;
  logic [DATA_W-1:0] s_data;
  logic              s_ready;

  modport master (output s_valid, output s_data, input s_ready);
  modport slave  (input s_valid, input s_data, output s_ready);
endinterface

// File: rtl/prog_wdt.sv
// Run watchdog: counts while the sequencer is expected to be running and
// reports expiry once the counter saturates at all-ones.
module prog_wdt #(
  parameter int WDT_W = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic i_clr,
  input  logic i_en,
  output logic o_expired
);

  logic [WDT_W-1:0] r_cnt;

  assign o_expired = &r_cnt;

  // Clear on request, otherwise count up and hold at the saturation value.
  always_ff @(posedge clk) begin
    if (rst || i_clr) begin
      r_cnt <= '0;
    end else if (i_en && !o_expired) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

endmodule

// File: rtl/prog_loader.sv
// Program loader: streams microinstructions into the sequencer program ROM,
// optionally launches the sequencer and tracks it until HALT.
// Optional watchdog on the run phase: define PROG_LOADER_WDT_EN.
module prog_loader
  import prog_loader_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF,
  parameter int WDT_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_load_req,
  input  logic [ADDR_W:0]   i_load_len,
  input  logic              i_run_req,
  prog_loader_if.slave      s_if,
  output logic              o_rom_we,
  output logic [ADDR_W-1:0] o_rom_waddr,
  output logic [DATA_W-1:0] o_rom_wdata,
  output logic              o_seq_start,
  input  logic              i_seq_ready,
  output logic              o_busy,
  output logic              o_done,
  output logic              o_err_cmd,
  output logic              o_err_wdt
);

  localparam logic [ADDR_W:0] DEPTH   = {1'b1, {ADDR_W{1'b0}}};
  localparam logic [ADDR_W:0] CNT_ONE = {{ADDR_W{1'b0}}, 1'b1};

  state_e            r_state, w_state_nxt;
  logic [ADDR_W:0]   r_len, r_cnt;
  logic              r_auto;
  logic              r_we, r_done, r_err_cmd, r_err_wdt;
  logic [ADDR_W-1:0] r_waddr;
  logic [DATA_W-1:0] r_wdata;

  logic              w_s_ready, w_hs, w_len_ok, w_accept_load;
  logic              w_done, w_err_cmd, w_wdt_hit, w_wdt_exp;
  logic [ADDR_W:0]   w_cnt_inc;

  // Ready is withheld once all words are in, so an auto-run load spends one
  // drain cycle in LOAD while the final write lands before ARM.
  assign w_s_ready   = (r_state == ST_LOAD) && (r_cnt != r_len);
  assign w_hs        = s_if.s_valid && w_s_ready;
  assign w_cnt_inc   = r_cnt + CNT_ONE;
  assign w_len_ok    = (i_load_len != '0) && (i_load_len <= DEPTH);

  assign s_if.s_ready = w_s_ready;
  assign o_rom_we     = r_we;
  assign o_rom_waddr  = r_waddr;
  assign o_rom_wdata  = r_wdata;
  assign o_seq_start  = (r_state == ST_ARM);
  assign o_busy       = (r_state != ST_IDLE);
  assign o_done       = r_done;
  assign o_err_cmd    = r_err_cmd;
  assign o_err_wdt    = r_err_wdt;

`ifdef PROG_LOADER_WDT_EN
  prog_wdt #(.WDT_W(WDT_W)) u_wdt (
    .clk       (clk),
    .rst       (rst),
    .i_clr     (r_state == ST_ARM),
    .i_en      ((r_state == ST_WLOW) || (r_state == ST_RUN)),
    .o_expired (w_wdt_exp)
  );
`else
  // No watchdog: the run phase never times out.
  assign w_wdt_exp = (WDT_W < 1);
`endif

  // Next-state and single-cycle event decode.
  always_comb begin
    w_state_nxt   = r_state;
    w_accept_load = 1'b0;
    w_done        = 1'b0;
    w_err_cmd     = 1'b0;
    w_wdt_hit     = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (i_load_req || i_run_req) begin
          if (!i_seq_ready) begin
            w_err_cmd = 1'b1;
          end else if (i_load_req) begin
            if (w_len_ok) begin
              w_accept_load = 1'b1;
              w_state_nxt   = ST_LOAD;
            end else begin
              w_err_cmd = 1'b1;
            end
          end else begin
            w_state_nxt = ST_ARM;
          end
        end
      end
      ST_LOAD: begin
        if (r_cnt == r_len) begin
          w_state_nxt = ST_ARM;
        end else if (w_hs && (w_cnt_inc == r_len) && !r_auto) begin
          w_done      = 1'b1;
          w_state_nxt = ST_IDLE;
        end
      end
      ST_ARM: begin
        w_state_nxt = ST_WLOW;
      end
      ST_WLOW: begin
        if (w_wdt_exp) begin
          w_wdt_hit   = 1'b1;
          w_state_nxt = ST_IDLE;
        end else if (!i_seq_ready) begin
          w_state_nxt = ST_RUN;
        end
      end
      ST_RUN: begin
        if (w_wdt_exp) begin
          w_wdt_hit   = 1'b1;
          w_state_nxt = ST_IDLE;
        end else if (i_seq_ready) begin
          w_done      = 1'b1;
          w_state_nxt = ST_IDLE;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  // State register and status pulses/flags.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= ST_IDLE;
      r_done    <= 1'b0;
      r_err_cmd <= 1'b0;
      r_err_wdt <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_done    <= w_done;
      r_err_cmd <= w_err_cmd;
      if (w_wdt_hit) begin
        r_err_wdt <= 1'b1;
      end
    end
  end

  // Load bookkeeping: length, auto-run flag and the write-address counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_len  <= '0;
      r_cnt  <= '0;
      r_auto <= 1'b0;
    end else if (w_accept_load) begin
      r_len  <= i_load_len;
      r_cnt  <= '0;
      r_auto <= i_run_req;
    end else if (w_hs) begin
      r_cnt  <= w_cnt_inc;
    end
  end

  // Registered ROM write port: one write per accepted stream word.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_we    <= 1'b0;
      r_waddr <= '0;
      r_wdata <= '0;
    end else begin
      r_we <= w_hs;
      if (w_hs) begin
        r_waddr <= r_cnt[ADDR_W-1:0];
        r_wdata <= s_if.s_data;
      end
    end
  end

endmodule

// File: doc/prog_loader.md
# prog_loader

Controller that configures and launches the microcode sequencer. It accepts a stream of 16-bit microinstructions over a valid/ready handshake and writes them into the sequencer's 256x16 program ROM through its programming port. It then optionally pulses the sequencer's start input and tracks its ready output until the program halts. It sits between the host/testbench interface and the sequencer, and is the only agent that drives the ROM write port and start.

## Interface
- `ADDR_W`, 8: ROM address width; the ROM depth is 2^ADDR_W.
- `DATA_W`, 16: microinstruction width.
- `WDT_W`, 16: watchdog counter width (used only when the watchdog is compiled in).
- `clk`  in  1  clock; all logic is on the rising edge.
- `rst`  in  1  reset; synchronous, active-high.
- `load_req`  in  1  one-cycle command: load `load_len` words starting at address 0.
- `load_len`  in  ADDR_W+1  word count, 1..2^ADDR_W; sampled with `load_req`.
- `run_req`  in  1  one-cycle command: start the sequencer, or auto-run after a load if it coincides with `load_req`.
- `s_valid`  in  1  stream word valid.
- `s_data`  in  DATA_W  stream word.
- `s_ready`  out  1  loader accepts a word this cycle.
- `rom_we`  out  1  ROM write strobe; connects to the sequencer `rom_we`.
- `rom_waddr`  out  ADDR_W  ROM write address.
- `rom_wdata`  out  DATA_W  ROM write data.
- `seq_start`  out  1  one-cycle start pulse to the sequencer.
- `seq_ready`  in  1  sequencer READY (1 = idle).
- `busy`  out  1  controller not in IDLE.
- `done`  out  1  one-cycle pulse: the load finished (no run requested) or the run finished.
- `err_cmd`  out  1  one-cycle pulse: command rejected.
- `err_wdt`  out  1  sticky watchdog expiry flag; cleared only by `rst`.

## Operation
- States: IDLE, LOAD, ARM, WLOW, RUN.
- **IDLE**
  - `s_ready`=0.
  - A command is accepted only if `seq_ready`=1. Otherwise `err_cmd` pulses and the command is dropped.
  - `load_req` with `load_len` in range: capture the length and the auto-run flag (the `run_req` value in the same cycle), clear the word counter, go to LOAD.
  - `load_req` with `load_len`=0 or `load_len`>2^ADDR_W: `err_cmd` pulses and the controller stays in IDLE.
  - `run_req` alone: go to ARM.
- **LOAD**
  - `s_ready`=1.
  - Each cycle with `s_valid`&`s_ready` produces a registered write on the next cycle: `rom_we`=1, `rom_waddr`=counter, `rom_wdata`=`s_data`. The counter then increments.
  - On the last word, `s_ready` drops in the following cycle. The controller goes to ARM if the auto-run flag is set; otherwise it returns to IDLE and pulses `done` in the same cycle as the final `rom_we`.
  - Words are written to contiguous addresses starting at 0. The counter never wraps, because the length is bounded.
  - `load_req`/`run_req` are ignored outside IDLE.
- **ARM**
  - Drive `seq_start`=1 for exactly one cycle, then go to WLOW.
  - Reaching ARM from LOAD requires the final `rom_we` to have already been issued.
- **WLOW**
  - Wait for `seq_ready`=0, which the sequencer asserts one cycle after sampling start, then go to RUN.
- **RUN**
  - Wait for `seq_ready`=1 (HALT reached), then pulse `done` and go to IDLE.
- **Reset**
  - From any state, `rst` forces IDLE. A partial load is abandoned; ROM contents already written remain.
  - The sequencer has its own reset and is not aborted by this block.

## Timing
- Reset values: `s_ready`=0, `rom_we`=0, `rom_waddr`=0, `rom_wdata`=0, `seq_start`=0, `busy`=0, `done`=0, `err_cmd`=0, `err_wdt`=0.
- Command-to-LOAD latency is 1 cycle. `s_ready` is first high in the cycle after `load_req`.
- Full-rate throughput is 1 word per cycle. `rom_we` lags each accepted word by 1 cycle.
- Run-only path: `seq_start` is high 1 cycle after `run_req`, and `done` follows no earlier than 3 cycles after `seq_start`.
- A program that halts at PC 0: `seq_ready` goes low for 1 cycle and high again; WLOW followed by RUN must catch this.

## Configuration
- `PROG_LOADER_WDT_EN` defined:
  - WDT_W counter, cleared on entry to WLOW and incremented in WLOW and RUN.
  - When the counter reaches all-ones, `err_wdt` is set (sticky), `done` is not pulsed, and the controller returns to IDLE.
- `PROG_LOADER_WDT_EN` undefined:
  - No counter is built and `err_wdt` is tied to 0.
  - WLOW and RUN wait indefinitely.

## Structure
- Package `prog_loader_pkg` holds:
  - the state encoding (IDLE=0, LOAD=1, ARM=2, WLOW=3, RUN=4, as a 3-bit type);
  - the default ADDR_W/DATA_W constants, shared with the sequencer;
  - the ctl_c HALT encoding 2'b10, used by benches.
- One natural sub-module: `prog_wdt`, the watchdog counter with clear, enable, and expired outputs. It is instantiated only under the macro.
- The FSM and the write-address counter stay in the top-level module.

## Test plan
- Load 4 words with no auto-run (`load_len`=4, data 0x1000..0x1003, `s_valid` continuous): `rom_we` at addresses 0..3 with matching data, `done` with the last write, no `seq_start`.
- Load 3 words with auto-run (`load_req`&`run_req`, `load_len`=3, word 2=0x0020 HALT, `s_valid` toggling every other cycle):
  - writes occur only on handshakes;
  - one `seq_start`;
  - sequencer pc_dbg stops at 2;
  - `done` pulses once.
- Command rejection: `load_len`=0 → `err_cmd`, `busy`=0. `run_req` while `seq_ready`=0 → `err_cmd`.
- Full depth: `load_len`=256 with random stall pattern → 256 writes, last at address 0xFF, then `done`.
- Reset mid-load: `rst` after 5 of 10 words → IDLE, `s_ready`=0. A new 2-word load then writes addresses 0..1.
- `PROG_LOADER_WDT_EN` with WDT_W=4 and a ROM loop with no HALT → `err_wdt`=1 within 16 cycles of `seq_start`, no `done`, `busy`=0.
